// File: rtl/mult_acc_ctrl.sv
// mult_acc_ctrl: accumulates signed products into dot-product results with a valid/ready result hold; define MULT_ACC_SAT_EN for saturating adds (wrapping otherwise)
module mult_acc_ctrl #(
    parameter int WIDTH     = 18,
    parameter int ACC_WIDTH = 48,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [2*WIDTH-1:0]   IN_PROD,
    input  logic                 IN_VALID,
    input  logic                 IN_LAST,
    output logic                 IN_READY,
    output logic [ACC_WIDTH-1:0] OUT_DATA,
    output logic [CNT_WIDTH-1:0] OUT_COUNT,
    output logic                 OUT_OVF,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY
);
    typedef enum logic {ACC, HOLD} state_t;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
`ifdef MULT_ACC_SAT_EN
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
`endif

    if (WIDTH != 16 && WIDTH != 18) begin : g_bad_width
        $error("mult_acc_ctrl: WIDTH must be 16 or 18, got %0d", WIDTH);
    end
    if (ACC_WIDTH < 2*WIDTH+1) begin : g_bad_acc_width
        $error("mult_acc_ctrl: ACC_WIDTH must be >= 2*WIDTH+1, got %0d", ACC_WIDTH);
    end

    state_t                 r_state;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic                   r_ovf;
    logic [ACC_WIDTH-1:0]   w_ext;
    logic [ACC_WIDTH-1:0]   w_raw;
    logic [ACC_WIDTH-1:0]   w_sum;
    logic [CNT_WIDTH-1:0]   w_cnt;
    logic                   w_vf;
    logic                   w_ovf;
    logic                   w_accept;

    assign IN_READY = (r_state == ACC);
    assign w_accept = IN_VALID & IN_READY;

    // next accumulator value with signed-overflow detection, clamped when saturation is enabled
    always_comb begin
        w_ext = {{(ACC_WIDTH-2*WIDTH){IN_PROD[2*WIDTH-1]}}, IN_PROD};
        w_raw = r_acc + w_ext;
        w_vf  = (r_acc[ACC_WIDTH-1] == w_ext[ACC_WIDTH-1]) && (w_raw[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);
`ifdef MULT_ACC_SAT_EN
        w_sum = w_vf ? (r_acc[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX) : w_raw;
`else
        w_sum = w_raw;
`endif
        w_cnt = &r_cnt ? r_cnt : r_cnt + CNT_ONE;
        w_ovf = r_ovf | w_vf;
    end

    // ACC gathers terms until the last one, HOLD presents the registered result until taken
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= ACC;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            OUT_DATA  <= '0;
            OUT_COUNT <= '0;
            OUT_OVF   <= 1'b0;
            OUT_VALID <= 1'b0;
        end else if (r_state == ACC) begin
            if (w_accept && IN_LAST) begin
                OUT_DATA  <= w_sum;
                OUT_COUNT <= w_cnt;
                OUT_OVF   <= w_ovf;
                OUT_VALID <= 1'b1;
                r_state   <= HOLD;
                r_acc     <= '0;
                r_cnt     <= '0;
                r_ovf     <= 1'b0;
            end else if (w_accept) begin
                r_acc <= w_sum;
                r_cnt <= w_cnt;
                r_ovf <= w_ovf;
            end
        end else if (OUT_READY) begin
            OUT_VALID <= 1'b0;
            r_state   <= ACC;
        end
    end
endmodule

// File: tb/tb_mult_acc_ctrl.sv
// tb_mult_acc_ctrl: randomized and directed checks of mult_acc_ctrl at ACC_WIDTH 48 and 37 against an integer reference model
module tb_mult_acc_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [35:0] in_prod = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready_a, in_ready_b;
    logic [47:0] out_data_a;
    logic [36:0] out_data_b;
    logic [15:0] out_count_a, out_count_b;
    logic        out_ovf_a, out_ovf_b, out_valid_a, out_valid_b;

    int     n_cmp = 0;
    int     n_bad = 0;
    longint m_acc[2] = '{0, 0};
    bit     m_ovf[2] = '{0, 0};
    int     m_cnt = 0;
    longint e_data[2];
    bit     e_ovf[2];
    logic [15:0] e_cnt;

    always #5 clk = ~clk;

    mult_acc_ctrl #(.WIDTH(18), .ACC_WIDTH(48), .CNT_WIDTH(16)) u_dut_a (
        .CLK(clk), .RST(rst), .IN_PROD(in_prod), .IN_VALID(in_valid), .IN_LAST(in_last),
        .IN_READY(in_ready_a), .OUT_DATA(out_data_a), .OUT_COUNT(out_count_a),
        .OUT_OVF(out_ovf_a), .OUT_VALID(out_valid_a), .OUT_READY(out_ready)
    );

    mult_acc_ctrl #(.WIDTH(18), .ACC_WIDTH(37), .CNT_WIDTH(16)) u_dut_b (
        .CLK(clk), .RST(rst), .IN_PROD(in_prod), .IN_VALID(in_valid), .IN_LAST(in_last),
        .IN_READY(in_ready_b), .OUT_DATA(out_data_b), .OUT_COUNT(out_count_b),
        .OUT_OVF(out_ovf_b), .OUT_VALID(out_valid_b), .OUT_READY(out_ready)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // exact sum, then clamp or wrap into the signed aw-bit range
    function automatic longint madd(input longint a, input longint p, input int aw, output bit o);
        longint r, hi, lo, span;
        span = longint'(1) << aw;
        hi = (span >>> 1) - 1;
        lo = -(span >>> 1);
        r = a + p;
        o = (r > hi) || (r < lo);
`ifdef MULT_ACC_SAT_EN
        if (r > hi) r = hi;
        else if (r < lo) r = lo;
`else
        if (r > hi) r -= span;
        else if (r < lo) r += span;
`endif
        return r;
    endfunction

    task automatic push(input longint p, input bit last);
        bit o;
        in_prod = 36'(p);
        in_valid = 1'b1;
        in_last = last;
        m_cnt++;
        for (int k = 0; k < 2; k++) begin
            m_acc[k] = madd(m_acc[k], p, k == 0 ? 48 : 37, o);
            m_ovf[k] |= o;
        end
        if (last) begin
            e_data = m_acc;
            e_ovf = m_ovf;
            e_cnt = 16'(m_cnt);
            m_acc = '{0, 0};
            m_ovf = '{0, 0};
            m_cnt = 0;
        end
        tick;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick;
    endtask

    task automatic release_result;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        m_acc = '{0, 0};
        m_ovf = '{0, 0};
        m_cnt = 0;
    endtask

    task automatic test_reset;
        in_valid = 1'b1;
        in_last = 1'b1;
        in_prod = 36'h0_0000_0123;
        out_ready = 1'b1;
        do_reset;
        in_valid = 1'b0;
        in_last = 1'b0;
        out_ready = 1'b0;
        n_cmp++;
        if ({in_ready_a, out_valid_a, out_data_a, out_count_a, out_ovf_a} !== {1'b1, 1'b0, 48'd0, 16'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_a: got rdy=%0b v=%0b d=%0d c=%0d o=%0b, want rdy=1 v=0 d=0 c=0 o=0",
                     in_ready_a, out_valid_a, $signed(out_data_a), out_count_a, out_ovf_a);
        end
        n_cmp++;
        if ({in_ready_b, out_valid_b, out_data_b, out_count_b, out_ovf_b} !== {1'b1, 1'b0, 37'd0, 16'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_b: got rdy=%0b v=%0b d=%0d c=%0d o=%0b, want rdy=1 v=0 d=0 c=0 o=0",
                     in_ready_b, out_valid_b, $signed(out_data_b), out_count_b, out_ovf_b);
        end
    endtask

    task automatic check_both(input string name);
        n_cmp++;
        if ({out_valid_a, out_data_a, out_count_a, out_ovf_a} !== {1'b1, 48'(e_data[0]), e_cnt, e_ovf[0]}) begin
            n_bad++;
            $display("FAIL %s_a: got v=%0b d=%0d c=%0d o=%0b, want v=1 d=%0d c=%0d o=%0b", name,
                     out_valid_a, $signed(out_data_a), out_count_a, out_ovf_a, e_data[0], e_cnt, e_ovf[0]);
        end
        n_cmp++;
        if ({out_valid_b, out_data_b, out_count_b, out_ovf_b} !== {1'b1, 37'(e_data[1]), e_cnt, e_ovf[1]}) begin
            n_bad++;
            $display("FAIL %s_b: got v=%0b d=%0d c=%0d o=%0b, want v=1 d=%0d c=%0d o=%0b", name,
                     out_valid_b, $signed(out_data_b), out_count_b, out_ovf_b, e_data[1], e_cnt, e_ovf[1]);
        end
    endtask

    task automatic test_basic;
        push(3, 0);
        push(-5, 0);
        n_cmp++;
        if ({out_valid_a, in_ready_a} !== 2'b01) begin
            n_bad++;
            $display("FAIL basic_mid: got v=%0b rdy=%0b, want v=0 rdy=1", out_valid_a, in_ready_a);
        end
        push(7, 1);
        n_cmp++;
        if ({out_valid_a, out_data_a, out_count_a, out_ovf_a, in_ready_a} !== {1'b1, 48'd5, 16'd3, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL basic: got v=%0b d=%0d c=%0d o=%0b rdy=%0b, want v=1 d=5 c=3 o=0 rdy=0",
                     out_valid_a, $signed(out_data_a), out_count_a, out_ovf_a, in_ready_a);
        end
    endtask

    task automatic test_hold;
        logic [47:0] sa;
        logic [36:0] sb;
        sa = out_data_a;
        sb = out_data_b;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_prod = 36'($urandom);
            in_last = 1'($urandom);
            tick;
            n_cmp++;
            if ({in_ready_a, in_ready_b, out_valid_a, out_data_a, out_data_b} !== {2'b00, 1'b1, sa, sb}) begin
                n_bad++;
                $display("FAIL hold_%0d: got rdy=%0b v=%0b d=%0d, want rdy=0 v=1 d=%0d",
                         i, in_ready_a, out_valid_a, $signed(out_data_a), $signed(sa));
            end
        end
        in_last = 1'b0;
        out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_cmp++;
        if ({out_valid_a, out_valid_b, in_ready_a, in_ready_b} !== 4'b0011) begin
            n_bad++;
            $display("FAIL hold_release: got v=%0b rdy=%0b, want v=0 rdy=1", out_valid_a, in_ready_a);
        end
    endtask

    task automatic test_single_neg;
        push(-(longint'(1) << 35), 1);
        n_cmp++;
        if ({out_data_a, out_count_a, out_ovf_a} !== {48'hFFF8_0000_0000, 16'd1, 1'b0}) begin
            n_bad++;
            $display("FAIL single_neg: got d=%0d c=%0d o=%0b, want d=-34359738368 c=1 o=0",
                     $signed(out_data_a), out_count_a, out_ovf_a);
        end
        check_both("single_neg");
        release_result;
    endtask

    task automatic test_overflow;
        longint big;
        big = (longint'(1) << 35) - 1;
        push(big, 0);
        push(big, 1);
        check_both("ovf_two");
        release_result;
        push(big, 0);
        push(big, 0);
        push(big, 1);
        check_both("ovf_pos");
        n_cmp++;
        if (out_ovf_b !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_flag: got o=%0b, want o=1", out_ovf_b);
        end
        release_result;
        push(-(longint'(1) << 35), 0);
        push(-(longint'(1) << 35), 0);
        push(-(longint'(1) << 35), 1);
        check_both("ovf_neg");
        release_result;
    endtask

    task automatic test_gaps;
        push(2, 0);
        idle(3);
        push(4, 1);
        n_cmp++;
        if ({out_data_a, out_count_a, out_ovf_b} !== {48'd6, 16'd2, 1'b0}) begin
            n_bad++;
            $display("FAIL gaps: got d=%0d c=%0d ob=%0b, want d=6 c=2 ob=0", $signed(out_data_a), out_count_a, out_ovf_b);
        end
        check_both("gaps");
        release_result;
    endtask

    task automatic test_reset_mid;
        push(100, 0);
        push(200, 0);
        do_reset;
        push(1, 0);
        push(1, 1);
        n_cmp++;
        if ({out_data_a, out_count_a} !== {48'd2, 16'd2}) begin
            n_bad++;
            $display("FAIL reset_mid: got d=%0d c=%0d, want d=2 c=2", $signed(out_data_a), out_count_a);
        end
        check_both("reset_mid");
        do_reset;
        n_cmp++;
        if ({out_valid_a, in_ready_a, out_data_a, out_count_a} !== {1'b0, 1'b1, 48'd0, 16'd0}) begin
            n_bad++;
            $display("FAIL reset_hold: got v=%0b rdy=%0b d=%0d c=%0d, want v=0 rdy=1 d=0 c=0",
                     out_valid_a, in_ready_a, $signed(out_data_a), out_count_a);
        end
    endtask

    task automatic test_random;
        logic signed [35:0] r;
        int len;
        for (int t = 0; t < 20; t++) begin
            len = int'($urandom_range(6, 1));
            for (int j = 0; j < len; j++) begin
                idle(int'($urandom_range(2, 0)));
                r = 36'({$urandom, $urandom});
                if ($urandom_range(1, 0) == 0) r = r >>> 20;
                push(longint'(r), j == len - 1);
            end
            check_both("random");
            idle(int'($urandom_range(3, 0)));
            release_result;
            n_cmp++;
            if ({out_valid_a, out_valid_b, in_ready_a, in_ready_b} !== 4'b0011) begin
                n_bad++;
                $display("FAIL random_release_%0d: got v=%0b rdy=%0b, want v=0 rdy=1", t, out_valid_a, in_ready_a);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_hold;
        test_single_neg;
        test_overflow;
        test_gaps;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
